// File: rtl/cnn_pkg.sv
// cnn_pkg: shared width, tap indices, FSM state and boundary value
// for the 3x3 CNN window generator.
package cnn_pkg;

  localparam int WIDTH = 8;

  localparam int TAP_NW = 1;
  localparam int TAP_N  = 2;
  localparam int TAP_NE = 3;
  localparam int TAP_W  = 4;
  localparam int TAP_C  = 5;
  localparam int TAP_E  = 6;
  localparam int TAP_SW = 7;
  localparam int TAP_S  = 8;
  localparam int TAP_SE = 9;

  typedef enum logic [1:0] {
    FILL,
    RUN,
    FLUSH
  } win_state_t;

  localparam int BND_ZERO = 0;

endpackage

// File: rtl/cnn_line_buffer.sv
// cnn_line_buffer: DEPTH x DATA_W circular RAM, one write and one
// registered read per cycle.
// Ports: clk, rst (async, high), we_i/waddr_i/wdata_i write side,
// raddr_i read address, rdata_o = mem[raddr_i] one cycle later.
module cnn_line_buffer
  import cnn_pkg::*;
#(
  parameter int DATA_W = WIDTH,
  parameter int DEPTH  = 64,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdata_q <= '0;
    else     rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/cnn_window_gen.sv
// cnn_window_gen: raster stream in, 3x3 neighbourhood W1..W9 out
// (W5 = centre), one window per pixel, in raster order.
// Ports: clk, rst (async, high); in_pix/in_valid/in_ready input
// stream; W1..W9/out_valid/out_ready/out_last window stream.
// Build option CNN_WIN_REPLICATE_EN: edge-replicate boundary
// instead of zero boundary.
module cnn_window_gen
  import cnn_pkg::*;
#(
  parameter int DATA_W = WIDTH,
  parameter int IMG_W  = 64,
  parameter int IMG_H  = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [DATA_W-1:0] in_pix,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic signed [DATA_W-1:0] W1,
  output logic signed [DATA_W-1:0] W2,
  output logic signed [DATA_W-1:0] W3,
  output logic signed [DATA_W-1:0] W4,
  output logic signed [DATA_W-1:0] W5,
  output logic signed [DATA_W-1:0] W6,
  output logic signed [DATA_W-1:0] W7,
  output logic signed [DATA_W-1:0] W8,
  output logic signed [DATA_W-1:0] W9,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_last
);

  localparam int N  = IMG_W * IMG_H;
  localparam int PW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int CW = $clog2(N + 1);

  localparam logic [PW-1:0] COL_LAST = PW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0] CNT_FILL = CW'(IMG_W);
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  win_state_t        state_q;
  logic [CW-1:0]     in_cnt_q;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [PW-1:0]     ocol_q;
  logic [RW-1:0]     orow_q;
  logic [DATA_W-1:0] c0_q [3];
  logic [DATA_W-1:0] c1_q [3];
  logic [DATA_W-1:0] win_q [1:9];
  logic [DATA_W-1:0] raw [1:9];
  logic [DATA_W-1:0] tap_d [1:9];
  logic [DATA_W-1:0] rd0, rd1;
  logic              out_valid_q, out_last_q;
  logic              slot_free, in_fire, fl_emit;
  logic              emit, step, last_xfer;

  assign slot_free = !out_valid_q || out_ready;
  assign in_ready  = !rst && (state_q != FLUSH) && slot_free;
  assign in_fire   = in_valid && in_ready;
  // Flush stops once the last window is waiting to be taken.
  assign fl_emit   = (state_q == FLUSH) && slot_free &&
                     !(out_valid_q && out_last_q);
  assign emit      = ((state_q == RUN) && in_fire) || fl_emit;
  assign step      = in_fire || fl_emit;
  assign last_xfer = out_valid_q && out_ready && out_last_q;

  always_comb begin
    ptr_d = ptr_q;
    if (last_xfer)
      ptr_d = '0;
    else if (step)
      ptr_d = (ptr_q == COL_LAST) ? '0 : ptr_q + 1'b1;
  end

  // Reads are issued at the next pointer so the word for the
  // current column is already registered when the pixel arrives.
  cnn_line_buffer #(
    .DATA_W (DATA_W),
    .DEPTH  (IMG_W)
  ) u_lb0 (
    .clk     (clk),
    .rst     (rst),
    .we_i    (step),
    .waddr_i (ptr_q),
    .wdata_i (in_pix),
    .raddr_i (ptr_d),
    .rdata_o (rd0)
  );

  cnn_line_buffer #(
    .DATA_W (DATA_W),
    .DEPTH  (IMG_W)
  ) u_lb1 (
    .clk     (clk),
    .rst     (rst),
    .we_i    (step),
    .waddr_i (ptr_q),
    .wdata_i (rd0),
    .raddr_i (ptr_d),
    .rdata_o (rd1)
  );

  // Right column comes straight from the buffers and input.
  always_comb begin
    raw[TAP_NW] = c0_q[0];
    raw[TAP_N]  = c1_q[0];
    raw[TAP_NE] = rd1;
    raw[TAP_W]  = c0_q[1];
    raw[TAP_C]  = c1_q[1];
    raw[TAP_E]  = rd0;
    raw[TAP_SW] = c0_q[2];
    raw[TAP_S]  = c1_q[2];
    raw[TAP_SE] = in_pix;
  end

`ifdef CNN_WIN_REPLICATE_EN
  // Columns first, then rows, so corners take the corner pixel.
  always_comb begin
    for (int i = 1; i <= 9; i++) tap_d[i] = raw[i];
    for (int r = 0; r < 3; r++) begin
      if (ocol_q == '0)
        tap_d[3*r+1] = raw[3*r+2];
      if (ocol_q == COL_LAST)
        tap_d[3*r+3] = raw[3*r+2];
    end
    if (orow_q == '0)
      for (int i = 1; i <= 3; i++) tap_d[i] = tap_d[i+3];
    if (orow_q == ROW_LAST)
      for (int i = 7; i <= 9; i++) tap_d[i] = tap_d[i-3];
  end
`else
  localparam logic [DATA_W-1:0] BND = DATA_W'(BND_ZERO);

  always_comb begin
    for (int i = 1; i <= 9; i++) tap_d[i] = raw[i];
    if (orow_q == '0) begin
      tap_d[TAP_NW] = BND;
      tap_d[TAP_N]  = BND;
      tap_d[TAP_NE] = BND;
    end
    if (orow_q == ROW_LAST) begin
      tap_d[TAP_SW] = BND;
      tap_d[TAP_S]  = BND;
      tap_d[TAP_SE] = BND;
    end
    if (ocol_q == '0) begin
      tap_d[TAP_NW] = BND;
      tap_d[TAP_W]  = BND;
      tap_d[TAP_SW] = BND;
    end
    if (ocol_q == COL_LAST) begin
      tap_d[TAP_NE] = BND;
      tap_d[TAP_E]  = BND;
      tap_d[TAP_SE] = BND;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= FILL;
      in_cnt_q    <= '0;
      ptr_q       <= '0;
      ocol_q      <= '0;
      orow_q      <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      for (int i = 1; i <= 9; i++) win_q[i] <= '0;
      for (int i = 0; i < 3; i++) begin
        c0_q[i] <= '0;
        c1_q[i] <= '0;
      end
    end else begin
      ptr_q <= ptr_d;
      if (step) begin
        c0_q    <= c1_q;
        c1_q[0] <= rd1;
        c1_q[1] <= rd0;
        c1_q[2] <= in_pix;
      end
      if (emit) begin
        win_q       <= tap_d;
        out_valid_q <= 1'b1;
        out_last_q  <= (orow_q == ROW_LAST) &&
                       (ocol_q == COL_LAST);
        if (ocol_q == COL_LAST) begin
          ocol_q <= '0;
          orow_q <= (orow_q == ROW_LAST) ? '0 : orow_q + 1'b1;
        end else begin
          ocol_q <= ocol_q + 1'b1;
        end
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
        out_last_q  <= 1'b0;
      end
      unique case (state_q)
        FILL: begin
          if (in_fire) begin
            in_cnt_q <= in_cnt_q + 1'b1;
            if (in_cnt_q == CNT_FILL) state_q <= RUN;
          end
        end
        RUN: begin
          if (in_fire) begin
            in_cnt_q <= in_cnt_q + 1'b1;
            if (in_cnt_q == CNT_LAST) state_q <= FLUSH;
          end
        end
        FLUSH: begin
          if (last_xfer) begin
            state_q  <= FILL;
            in_cnt_q <= '0;
            ocol_q   <= '0;
            orow_q   <= '0;
          end
        end
        default: state_q <= FILL;
      endcase
    end
  end

  assign W1        = win_q[TAP_NW];
  assign W2        = win_q[TAP_N];
  assign W3        = win_q[TAP_NE];
  assign W4        = win_q[TAP_W];
  assign W5        = win_q[TAP_C];
  assign W6        = win_q[TAP_E];
  assign W7        = win_q[TAP_SW];
  assign W8        = win_q[TAP_S];
  assign W9        = win_q[TAP_SE];
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_cnn_window_gen.sv
// tb_cnn_window_gen: scoreboard bench for cnn_window_gen on a
// 4x4 image; expected windows come from a golden neighbourhood model.
module tb_cnn_window_gen;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic signed [7:0] in_pix = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic signed [7:0] W1, W2, W3, W4, W5, W6, W7, W8, W9;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic              out_last;

  cnn_window_gen #(
    .DATA_W (8),
    .IMG_W  (4),
    .IMG_H  (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_pix    (in_pix),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .W1        (W1),
    .W2        (W2),
    .W3        (W3),
    .W4        (W4),
    .W5        (W5),
    .W6        (W6),
    .W7        (W7),
    .W8        (W8),
    .W9        (W9),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last)
  );

  initial forever #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          n_out = 0;
  int          n_last = 0;
  int          out_idx = 0;
  int          last_edge = 0;
  int          ordy_mode = 0;
  int          stall_n = 0;
  bit          ramp = 0;
  bit          in_flush = 0;
  bit          lat_pend = 0;
  bit          lat_exp = 0;
  logic [7:0]  cur_frame [16];
  logic [72:0] exp_q [$];
  logic [72:0] k0, k5, k15;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [72:0] got,
                     input logic [72:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [72:0] mk9(
    input int a, input int b, input int c,
    input int d, input int e, input int f,
    input int g, input int h, input int i,
    input bit l);
    return {8'(a), 8'(b), 8'(c), 8'(d), 8'(e),
            8'(f), 8'(g), 8'(h), 8'(i), l};
  endfunction

  function automatic logic [72:0] gold(input int k);
    logic [71:0] t;
    logic [7:0]  px;
    int          r, c, rr, cc;
    t = '0;
    r = k / 4;
    c = k % 4;
    for (int dr = -1; dr <= 1; dr++) begin
      for (int dc = -1; dc <= 1; dc++) begin
        rr = r + dr;
        cc = c + dc;
`ifdef CNN_WIN_REPLICATE_EN
        if (rr < 0) rr = 0;
        if (rr > 3) rr = 3;
        if (cc < 0) cc = 0;
        if (cc > 3) cc = 3;
        px = cur_frame[rr*4+cc];
`else
        if (rr < 0 || rr > 3 || cc < 0 || cc > 3) px = 8'd0;
        else px = cur_frame[rr*4+cc];
`endif
        t = {t[63:0], px};
      end
    end
    return {t, (k == 15)};
  endfunction

  function automatic logic [72:0] obs();
    return {W1, W2, W3, W4, W5, W6, W7, W8, W9, out_last};
  endfunction

  // Output side: pops the scoreboard on every window transfer.
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      if (lat_pend) begin
        chk("latency", out_valid, lat_exp);
        lat_pend = 0;
      end
      if (in_flush) chk("flush_rdy", in_ready, 1'b0);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected", 1'b1, 1'b0);
        end else begin
          chk("win", obs(), exp_q.pop_front());
        end
        if (ramp && out_idx == 0)  chk("ramp_k0", obs(), k0);
        if (ramp && out_idx == 5)  chk("ramp_k5", obs(), k5);
        if (ramp && out_idx == 15) chk("ramp_k15", obs(), k15);
        n_out++;
        out_idx++;
        if (out_last) begin
          n_last++;
          out_idx = 0;
          in_flush = 0;
          last_edge = cyc + 1;
        end
      end else if (out_valid) begin
        if (exp_q.size() == 0) chk("stall_q", 1'b1, 1'b0);
        else chk("hold", obs(), exp_q[0]);
        chk("stall_rdy", in_ready, 1'b0);
      end
    end
  end

  // Downstream ready pattern.
  initial forever begin
    @(posedge clk);
    #1;
    case (ordy_mode)
      1: out_ready = ($urandom_range(0, 3) != 0);
      2: begin
        if (out_valid && out_idx == 7 && stall_n < 3) begin
          out_ready = 1'b0;
          stall_n++;
        end else begin
          out_ready = 1'b1;
        end
      end
      default: out_ready = 1'b1;
    endcase
  end

  task automatic send_frame(input int npix, input int vpct,
                            input bit b2b);
    for (int i = 0; i < npix; i++) begin
      int n;
      bit acc;
      n = 0;
      acc = 0;
      in_pix = cur_frame[i];
      while (!acc) begin
        in_valid = ($urandom_range(0, 99) < vpct);
        @(negedge clk);
        acc = in_valid && in_ready;
        @(posedge clk);
        #1;
        n++;
        if (n > 2000) begin
          chk("in_timeout", 1'b1, 1'b0);
          in_valid = 1'b0;
          return;
        end
      end
      exp_q.push_back(gold(i));
      lat_exp = (i >= 5);
      lat_pend = 1;
      if (i == 15) in_flush = 1;
      if (i == 0 && b2b) chk("b2b", cyc - last_edge, 1);
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 1000) begin
      @(posedge clk);
      n++;
    end
    chk("drain", exp_q.size(), 0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic load_ramp();
    for (int i = 0; i < 16; i++) cur_frame[i] = 8'(i + 1);
  endtask

  task automatic load_rand();
    for (int i = 0; i < 16; i++) cur_frame[i] = 8'($urandom);
  endtask

  initial begin
    int base_o, base_l;
`ifdef CNN_WIN_REPLICATE_EN
    k0  = mk9(1, 1, 2, 1, 1, 2, 5, 5, 6, 0);
    k15 = mk9(11, 12, 12, 15, 16, 16, 15, 16, 16, 1);
`else
    k0  = mk9(0, 0, 0, 0, 1, 2, 0, 5, 6, 0);
    k15 = mk9(11, 12, 0, 15, 16, 0, 0, 0, 0, 1);
`endif
    k5 = mk9(1, 2, 3, 5, 6, 7, 9, 10, 11, 0);

    repeat (3) @(negedge clk);
    chk("rst_win", obs(), '0);
    chk("rst_vld", out_valid, 1'b0);
    chk("rst_rdy", in_ready, 1'b0);
    chk("rst_last", out_last, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Ramp frame twice, back to back, full throughput.
    ramp = 1;
    load_ramp();
    base_o = n_out;
    base_l = n_last;
    send_frame(16, 100, 0);
    send_frame(16, 100, 1);
    drain();
    chk("t1_outs", n_out - base_o, 32);
    chk("t1_lasts", n_last - base_l, 2);

    // Three-cycle downstream stall at output 7.
    ordy_mode = 2;
    stall_n = 0;
    base_o = n_out;
    send_frame(16, 100, 0);
    drain();
    chk("t3_outs", n_out - base_o, 16);
    chk("t3_stalls", stall_n, 3);
    ordy_mode = 0;

    // Reset in the middle of a frame.
    send_frame(10, 100, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("mrst_win", obs(), '0);
    chk("mrst_vld", out_valid, 1'b0);
    chk("mrst_rdy", in_ready, 1'b0);
    exp_q.delete();
    in_flush = 0;
    lat_pend = 0;
    out_idx = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    base_o = n_out;
    send_frame(16, 100, 0);
    drain();
    chk("t4_outs", n_out - base_o, 16);

    // Two random frames, random handshakes.
    ramp = 0;
    ordy_mode = 1;
    base_o = n_out;
    base_l = n_last;
    load_rand();
    send_frame(16, 60, 0);
    load_rand();
    send_frame(16, 60, 0);
    drain();
    chk("t5_outs", n_out - base_o, 32);
    chk("t5_lasts", n_last - base_l, 2);
    ordy_mode = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
